// File: rtl/demod_pkg.sv
// Shared demodulator front-end definitions: ADC frame geometry and the
// capture-controller state encoding.
package demod_pkg;

    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_DATA_W     = 12;
    localparam int BIT_CNT_W      = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        QUIET
    } adc_state_e;

endpackage

// File: rtl/pos_edge_det.sv
// Rising-edge detector for a level signal sampled in the clk domain.
// RESET_VAL sets the assumed previous level, so a signal already high at reset release can be ignored.
module pos_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_d <= RESET_VAL;
        end else begin
            sig_d <= sig;
        end
    end

    assign rise = sig & ~sig_d;

endmodule

// File: rtl/adc_sample_ctrl.sv
// Serial ADC capture controller: a rising edge of the divided sample clock
// starts one 16-bit SPI frame; the low 12 bits are presented on dout with a one-cycle strobe.
module adc_sample_ctrl
    import demod_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int QUIET_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  samp_clk,
    input  logic                  adc_sdata,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    output logic [ADC_DATA_W-1:0] dout,
    output logic                  dout_valid,
    output logic                  overrun
);

    localparam int CNT_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'((QUIET_CYC >= 2) ? (QUIET_CYC - 2) : 0);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(ADC_FRAME_BITS);

    adc_state_e            state;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [ADC_DATA_W-1:0] shreg;
    logic                  trigger;

    pos_edge_det #(
        .RESET_VAL (1'b1)
    ) u_samp_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (samp_clk),
        .rise (trigger)
    );

    // Only the last 12 bits shifted in survive; the four leading frame bits age out of the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            overrun    <= trigger && (state != IDLE);
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state    <= SETUP;
                        adc_cs_n <= 1'b0;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                    end
                end
                SETUP: begin
                    if (cnt == HALF_LAST) begin
                        state    <= SHIFT;
                        adc_sclk <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (!adc_sclk) begin
                            adc_sclk <= 1'b1;
                            shreg    <= {shreg[ADC_DATA_W-2:0], adc_sdata};
                            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                        end else if (bit_cnt == LAST_BIT) begin
                            state      <= DONE;
                            adc_cs_n   <= 1'b1;
                            dout       <= shreg;
                            dout_valid <= 1'b1;
                        end else begin
                            adc_sclk <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= (QUIET_CYC > 1) ? QUIET : IDLE;
                end
                QUIET: begin
                    if (cnt == QUIET_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Self-checking bench for adc_sample_ctrl: directed frame table, sample-rate
// sequences and randomized triggers checked against a cycle-timing reference model.
module tb_adc_sample_ctrl;

    localparam int CD      = 2;
    localparam int QC      = 4;
    localparam int CONV    = 1 + 33 * CD;
    localparam int SPACING = CONV + QC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        samp_clk = 1'b0;
    logic        adc_sdata = 1'b0;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [11:0] dout;
    logic        dout_valid;
    logic        overrun;

    adc_sample_ctrl #(
        .CLK_DIV   (CD),
        .QUIET_CYC (QC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .samp_clk   (samp_clk),
        .adc_sdata  (adc_sdata),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, all expressed as absolute cycle numbers
    int          conv_t = -100000;
    int          valid_cyc = -1;
    int          ovr_cyc = -1;
    int          busy_until = 0;
    logic        m_samp_d = 1'b1;
    logic [11:0] m_dout = 12'h000;
    logic [11:0] pend = 12'h000;
    logic [15:0] next_frame = 16'h0000;
    logic [15:0] acc_frame = 16'h0000;
    bit          chk_on = 1'b0;
    int          seen_valid_cyc = -1;
    logic [11:0] seen_dout = 12'h000;
    int          valid_seen = 0;
    int          ovr_seen = 0;

    // ADC model: loads the accepted frame on cs_n fall, presents the next bit after each falling sclk
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;
    logic [15:0] frame_l = 16'h0000;
    int          falls = 0;

    always @(negedge clk) begin
        if (adc_cs_n !== 1'b0) begin
            falls     <= 0;
            adc_sdata <= 1'($urandom);
        end else begin
            if (prev_cs === 1'b1) frame_l <= acc_frame;
            if (prev_sclk === 1'b1 && adc_sclk === 1'b0 && falls < 16) begin
                adc_sdata <= frame_l[15 - falls];
                falls     <= falls + 1;
            end
        end
        prev_cs   <= adc_cs_n;
        prev_sclk <= adc_sclk;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic checkOutput();
        int   off;
        logic e_cs;
        logic e_sclk;
        if (chk_on) begin
            if (cyc == valid_cyc) m_dout = pend;
            off    = cyc - (conv_t + 1);
            e_cs   = !(off >= 0 && off < 33 * CD);
            e_sclk = 1'b1;
            if (off >= CD && off < 33 * CD) e_sclk = (((off - CD) / CD) % 2) == 1;
            cmp("cs_n", 32'(adc_cs_n), 32'(e_cs));
            cmp("sclk", 32'(adc_sclk), 32'(e_sclk));
            cmp("dout_valid", 32'(dout_valid), 32'(cyc == valid_cyc));
            cmp("overrun", 32'(overrun), 32'(cyc == ovr_cyc));
            cmp("dout", 32'(dout), 32'(m_dout));
            if (dout_valid === 1'b1) begin
                seen_valid_cyc = cyc;
                seen_dout      = dout;
                valid_seen++;
            end
            if (overrun === 1'b1) ovr_seen++;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        @(negedge clk);
        checkOutput();
        if (r) begin
            m_samp_d   = 1'b1;
            conv_t     = -100000;
            valid_cyc  = -1;
            ovr_cyc    = -1;
            busy_until = cyc + 1;
            m_dout     = 12'h000;
        end else begin
            if (s && !m_samp_d) begin
                if (cyc >= busy_until) begin
                    conv_t     = cyc;
                    valid_cyc  = cyc + CONV;
                    acc_frame  = next_frame;
                    pend       = next_frame[11:0];
                    busy_until = cyc + SPACING;
                end else begin
                    ovr_cyc = cyc + 1;
                end
            end
            m_samp_d = s;
        end
        samp_clk = s;
        rst      = r;
        if (r) chk_on = 1'b1;
    endtask

    task automatic hold(input logic s, input int n);
        for (int k = 0; k < n; k++) applyStimulus(s, 1'b0);
    endtask

    typedef struct {
        logic [15:0] frame;
        logic [11:0] exp_dout;
        int          exp_lat;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int trig;
        int v0;
        int o0;
        int len;
        logic s;

        tbl[0] = '{16'h0ABC, 12'hABC, 67};
        tbl[1] = '{16'hF555, 12'h555, 67};
        tbl[2] = '{16'h0FFF, 12'hFFF, 67};
        tbl[3] = '{16'h0000, 12'h000, 67};

        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1);
        hold(1'b0, 5);

        // Directed frames with exact latency
        for (int i = 0; i < 4; i++) begin
            next_frame = tbl[i].frame;
            hold(1'b0, 5);
            applyStimulus(1'b1, 1'b0);
            trig = cyc;
            seen_valid_cyc = -1;
            for (int k = 0; k < 200 && seen_valid_cyc < 0; k++) applyStimulus(1'b1, 1'b0);
            if (seen_valid_cyc < 0) begin
                cmp("tbl_timeout", 32'd0, 32'd1);
            end else begin
                cmp("tbl_dout", 32'(seen_dout), 32'(tbl[i].exp_dout));
                cmp("tbl_latency", 32'(seen_valid_cyc - trig), 32'(tbl[i].exp_lat));
            end
            hold(1'b1, 10);
        end

        // Free-running 100-cycle sample clock
        hold(1'b0, 10);
        v0 = valid_seen;
        o0 = ovr_seen;
        for (int i = 0; i < 8; i++) begin
            next_frame = {4'($urandom), 12'h200 + 12'(i)};
            hold(1'b1, 50);
            hold(1'b0, 50);
        end
        cmp("free_run_strobes", 32'(valid_seen - v0), 32'd8);
        cmp("free_run_overruns", 32'(ovr_seen - o0), 32'd0);

        // 60-cycle period: second trigger lands mid-frame
        v0 = valid_seen;
        o0 = ovr_seen;
        for (int i = 0; i < 3; i++) begin
            next_frame = 16'h0300 + 16'(i);
            hold(1'b1, 30);
            hold(1'b0, 30);
        end
        hold(1'b0, 80);
        cmp("fast_overruns", 32'(ovr_seen - o0), 32'd1);
        cmp("fast_strobes", 32'(valid_seen - v0), 32'd2);

        // Reset around bit 7 of the shift phase
        next_frame = 16'h0123;
        hold(1'b0, 5);
        applyStimulus(1'b1, 1'b0);
        hold(1'b1, 31);
        applyStimulus(1'b1, 1'b1);
        v0 = valid_seen;
        hold(1'b1, 80);
        cmp("reset_no_strobe", 32'(valid_seen - v0), 32'd0);
        next_frame = 16'h0456;
        hold(1'b0, 5);
        v0 = valid_seen;
        hold(1'b1, 80);
        cmp("after_reset_strobe", 32'(valid_seen - v0), 32'd1);
        cmp("after_reset_dout", 32'(seen_dout), 32'h456);

        // Reset released with samp_clk already high
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1);
        v0 = valid_seen;
        hold(1'b1, 100);
        cmp("high_release_no_conv", 32'(valid_seen - v0), 32'd0);
        next_frame = 16'hA789;
        hold(1'b0, 3);
        hold(1'b1, 80);
        cmp("high_release_dout", 32'(seen_dout), 32'h789);

        // Randomized trigger spacing, frames and occasional resets
        for (int i = 0; i < 40; i++) begin
            len        = int'($urandom_range(1, 120));
            s          = 1'($urandom);
            next_frame = 16'($urandom);
            if ($urandom_range(0, 30) == 0) applyStimulus(s, 1'b1);
            hold(s, len);
        end
        hold(1'b0, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

Serial-ADC capture controller that consumes the divided sample clock from the 50 MHz → sample-rate divider in the demodulator front end. Each rising edge of the divided clock starts one conversion on a 12-bit SPI-style ADC: 16 bits in, MSB first, with 4 leading zeros then 12 data bits. The 12-bit result goes to the demodulator datapath with a one-cycle valid strobe. Everything runs on the 50 MHz system clock; the divided clock is treated as data, never as a clock.

## Interface
- CLK_DIV, 2, system-clock cycles per SCLK half-period (SCLK = clk/(2·CLK_DIV)); legal range ≥1
- QUIET_CYC, 4, minimum cycles with adc_cs_n high between conversions; legal range ≥1
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous, active-high reset
- samp_clk  in  1  divided sample clock, registered in the clk domain; rising edge = start request
- adc_sdata  in  1  ADC serial data out
- adc_cs_n  out  1  ADC chip select, active low, registered
- adc_sclk  out  1  ADC serial clock, idle high, registered
- dout  out  12  last converted sample, held until the next conversion
- dout_valid  out  1  one-cycle strobe, dout updated this cycle
- overrun  out  1  one-cycle pulse, start request dropped because busy

Reset is rst, synchronous, active-high; the clock is clk.

## Operation
- Edge detect: samp_d <= samp_clk each cycle. Trigger = samp_clk & ~samp_d. samp_d resets to 1, so samp_clk already high at reset release does not trigger.
- States:
  - IDLE: cs_n=1, sclk=1. On trigger, go to SETUP and drive cs_n=0 next cycle.
  - SETUP: hold cs_n low for CLK_DIV cycles, sclk=1, then go to SHIFT.
  - SHIFT: 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high. On the cycle sclk is driven 0→1, shift adc_sdata into shreg[15:0] LSB end (MSB first). After the 16th high phase completes, go to DONE.
  - DONE (1 cycle): cs_n=1, dout<=shreg[11:0], dout_valid=1, then go to QUIET.
  - QUIET: cs_n=1 for QUIET_CYC−1 more cycles, then IDLE.
- shreg[15:12] are discarded, whatever their value.
- Counters: half-period counter width ≥ clog2(CLK_DIV+1); bit counter 5 bits, 0..16; no wrap beyond 16.
- Trigger in any state other than IDLE: request ignored, overrun=1 for that cycle, conversion in progress unaffected.
- Trigger in the same cycle as the QUIET→IDLE transition: counts as busy, so overrun.
- Reset at any time, including mid-SHIFT: next cycle cs_n=1, sclk=1, state IDLE, shreg=0, dout=0, dout_valid=0, overrun=0, samp_d=1. A partial sample is never presented.

## Timing
- Reset values: adc_cs_n=1, adc_sclk=1, dout=12'h000, dout_valid=0, overrun=0.
- Trigger detected in cycle T:
  - cs_n falls at T+1.
  - First sclk fall at T+1+CLK_DIV.
  - Bit k rising edge (sample) at T+1+(2k+2)·CLK_DIV, k=0..15.
  - dout_valid and cs_n rise at T+1+33·CLK_DIV. With defaults this is T+67.
- Minimum trigger spacing without overrun: 1+33·CLK_DIV+QUIET_CYC cycles (71 at defaults). A 100-cycle samp_clk period fits.
- adc_sdata must be stable in the last low-phase cycle before each rising sclk. The ADC updates on falling sclk, giving CLK_DIV cycles of setup.

## Structure
- Shared package (demod_pkg) holds:
  - ADC_FRAME_BITS=16
  - ADC_DATA_W=12
  - state enum {IDLE, SETUP, SHIFT, DONE, QUIET}
- Sub-module pos_edge_det holds the samp_d register and trigger output, with a reset value parameter (1 here). The divider and other strobe consumers reuse it.
- The FSM, counters and shifter stay in adc_sample_ctrl.

## Test plan
- ADC model returns frame 16'h0ABC on trigger at T → adc_cs_n low T+1..T+66, 16 sclk pulses, dout=12'hABC with dout_valid=1 at exactly T+67 and for one cycle only.
- Frame 16'hF555 (nonzero leading bits) → dout=12'h555; frame 16'h0FFF → 12'hFFF; frame 16'h0000 → 12'h000.
- Free-running samp_clk with 100-cycle period, 8 frames of incrementing values → 8 dout_valid strobes 100 cycles apart, correct data, overrun never set.
- samp_clk period 60 cycles → second trigger lands in SHIFT; overrun pulses that cycle, current frame completes unchanged, next accepted trigger converts normally.
- Assert rst for 1 cycle at bit 7 of SHIFT → next cycle cs_n=1, sclk=1, dout=0, no dout_valid; next samp_clk rising edge produces a correct full conversion.
- Release rst with samp_clk held high → no conversion until samp_clk goes low then high.
